// File: rtl/sweep_frame_packer.sv
// sweep_frame_packer
// Slices the decimated packed I/Q stream ({I[31:16], Q[15:0]}) into fixed-length
// range frames, one per sweep trigger, and emits them on an AXI4-Stream master
// with tlast. A small first-word-fall-through FIFO absorbs DMA backpressure.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   en_i              arming enable
//   trig_i            sweep start (rising edge detected internally)
//   frame_len_i       samples per frame, latched on an accepted trigger
//   s_valid_i/s_data_i input sample stream, no backpressure upstream
//   m_axis_*          AXI4-Stream master (tdata, tvalid, tready, tlast)
//   busy_o            accepted trigger .. tlast handshake
//   overflow_o        sticky: a non-final sample was dropped
//   trig_miss_o       sticky: trigger seen while busy
//   frame_cnt_o       completed frames (tlast handshakes), wraps
//   clr_flags_i       clears both sticky flags (a same-cycle set wins)
module sweep_frame_packer #(
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              trig_i,
  input  logic [LEN_W-1:0]  frame_len_i,
  input  logic              s_valid_i,
  input  logic [DATA_W-1:0] s_data_i,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              busy_o,
  output logic              overflow_o,
  output logic              trig_miss_o,
  output logic [31:0]       frame_cnt_o,
  input  logic              clr_flags_i
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  // Occupancy limits: a non-final sample must leave one slot free so the
  // final (tlast) sample always finds room.
  localparam logic [CW-1:0] LIM_LAST = CW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] LIM_BODY = CW'(FIFO_DEPTH - 2);

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

  state_t            state;
  logic              trig_d;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  cnt;

  logic [DATA_W:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;

  logic trig_rise;
  logic is_last;
  logic room;
  logic cap;
  logic wr_en;
  logic drop;
  logic rd_en;
  logic last_hs;

  assign trig_rise = trig_i & ~trig_d;
  assign is_last   = (cnt == len - LEN_W'(1));
  assign room      = is_last ? (count <= LIM_LAST) : (count <= LIM_BODY);
  assign cap       = (state == CAPTURE) && s_valid_i;
  assign wr_en     = cap && room;
  assign drop      = cap && !room;

  // FWFT head is presented straight from the storage array.
  assign m_axis_tvalid = (count != '0);
  assign m_axis_tdata  = mem[rd_ptr][DATA_W-1:0];
  assign m_axis_tlast  = m_axis_tvalid && mem[rd_ptr][DATA_W];
  assign rd_en         = m_axis_tvalid && m_axis_tready;
  assign last_hs       = rd_en && m_axis_tlast;

  // Control FSM, frame counter and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      trig_d      <= 1'b0;
      len         <= '0;
      cnt         <= '0;
      busy_o      <= 1'b0;
      overflow_o  <= 1'b0;
      trig_miss_o <= 1'b0;
      frame_cnt_o <= '0;
    end else begin
      trig_d <= trig_i;
      case (state)
        IDLE: begin
          if (trig_rise && en_i && (frame_len_i != '0)) begin
            len    <= frame_len_i;
            cnt    <= '0;
            busy_o <= 1'b1;
            state  <= CAPTURE;
          end
        end
        CAPTURE: begin
          // Dropped samples still advance cnt to keep range bins aligned.
          if (s_valid_i) begin
            cnt <= cnt + LEN_W'(1);
            if (is_last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_hs) begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (last_hs) frame_cnt_o <= frame_cnt_o + 32'd1;

      if (drop)                          overflow_o  <= 1'b1;
      else if (clr_flags_i)              overflow_o  <= 1'b0;
      if (trig_rise && state != IDLE)    trig_miss_o <= 1'b1;
      else if (clr_flags_i)              trig_miss_o <= 1'b0;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {is_last, s_data_i};
  end

endmodule

// File: tb/tb_sweep_frame_packer.sv
// Directed self-checking bench for sweep_frame_packer.
module tb_sweep_frame_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_i;
  logic        trig_i;
  logic [15:0] frame_len_i;
  logic        s_valid_i;
  logic [31:0] s_data_i;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        busy_o;
  logic        overflow_o;
  logic        trig_miss_o;
  logic [31:0] frame_cnt_o;
  logic        clr_flags_i;

  int checks = 0;
  int errors = 0;

  logic [31:0] q_data [$];
  logic        q_last [$];

  sweep_frame_packer #(.DATA_W(32), .LEN_W(16), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .en_i(en_i), .trig_i(trig_i), .frame_len_i(frame_len_i),
    .s_valid_i(s_valid_i), .s_data_i(s_data_i),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .busy_o(busy_o), .overflow_o(overflow_o), .trig_miss_o(trig_miss_o),
    .frame_cnt_o(frame_cnt_o), .clr_flags_i(clr_flags_i)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after posedge; handshakes are recorded at negedge,
  // i.e. the beats that the next posedge will consume.
  always @(negedge clk) begin
    if (!rst && m_axis_tvalid && m_axis_tready) begin
      q_data.push_back(m_axis_tdata);
      q_last.push_back(m_axis_tlast);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    trig_i = 1'b0; s_valid_i = 1'b0; s_data_i = '0; clr_flags_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en_i = 1'b0; frame_len_i = '0; m_axis_tready = 1'b1;
    idle_inputs();
    step(); step();
    checks++;
    if ({m_axis_tvalid, m_axis_tlast, busy_o, overflow_o, trig_miss_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outs got %b want 00000",
               {m_axis_tvalid, m_axis_tlast, busy_o, overflow_o, trig_miss_o});
    end
    checks++;
    if (frame_cnt_o !== 32'd0) begin
      errors++; $display("FAIL reset_cnt got %0d want 0", frame_cnt_o);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    q_data.delete(); q_last.delete();
    en_i = 1'b1; frame_len_i = 16'd8; m_axis_tready = 1'b1;
    trig_i = 1'b1; s_valid_i = 1'b1; s_data_i = 32'hDEADBEEF;  // same-cycle sample ignored
    step();
    trig_i = 1'b0;
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy_o); end
    for (int i = 1; i <= 8; i++) begin
      s_data_i = {16'(i), 16'(i)};
      step();
    end
    s_data_i = 32'h0BAD0BAD;  // DRAIN accepts no input
    step(); step(); step();
    s_valid_i = 1'b0;
    for (int t = 0; t < 20 && busy_o; t++) step();
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL basic_done got busy %b want 0", busy_o); end
    checks++;
    if (q_data.size() != 8) begin
      errors++; $display("FAIL basic_beats got %0d want 8", q_data.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (q_data[i] !== {16'(i+1), 16'(i+1)} || q_last[i] !== (i == 7)) begin
          errors++;
          $display("FAIL basic_beat%0d got %h/%b want %h/%b", i, q_data[i], q_last[i],
                   {16'(i+1), 16'(i+1)}, (i == 7));
        end
      end
    end
    checks++;
    if (frame_cnt_o !== 32'd1 || overflow_o !== 1'b0) begin
      errors++; $display("FAIL basic_cnt got %0d/%b want 1/0", frame_cnt_o, overflow_o);
    end
  endtask

  task automatic test_overflow();
    q_data.delete(); q_last.delete();
    m_axis_tready = 1'b0; frame_len_i = 16'd40;
    trig_i = 1'b1;
    step();
    trig_i = 1'b0; s_valid_i = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      s_data_i = 32'(i);
      step();
    end
    s_valid_i = 1'b0;
    step(); step();
    checks++;
    if (m_axis_tvalid !== 1'b1 || busy_o !== 1'b1 || overflow_o !== 1'b1 || q_data.size() != 0) begin
      errors++;
      $display("FAIL ovf_hold got v%b b%b o%b n%0d want v1 b1 o1 n0",
               m_axis_tvalid, busy_o, overflow_o, q_data.size());
    end
    m_axis_tready = 1'b1;
    for (int t = 0; t < 40 && busy_o; t++) step();
    checks++;
    if (q_data.size() != 16) begin
      errors++; $display("FAIL ovf_beats got %0d want 16", q_data.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (q_data[i] !== ((i == 15) ? 32'd40 : 32'(i+1)) || q_last[i] !== (i == 15)) begin
          errors++;
          $display("FAIL ovf_beat%0d got %0d/%b want %0d/%b", i, q_data[i], q_last[i],
                   (i == 15) ? 40 : i+1, (i == 15));
        end
      end
    end
    checks++;
    if (frame_cnt_o !== 32'd2) begin errors++; $display("FAIL ovf_cnt got %0d want 2", frame_cnt_o); end
    clr_flags_i = 1'b1;
    step();
    clr_flags_i = 1'b0;
    checks++;
    if (overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b want 0", overflow_o); end
  endtask

  task automatic test_trig_miss();
    q_data.delete(); q_last.delete();
    m_axis_tready = 1'b1; frame_len_i = 16'd8;
    trig_i = 1'b1;
    step();
    trig_i = 1'b0; s_valid_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      trig_i = (i == 3);
      s_data_i = 32'hA000_0000 | 32'(i);
      step();
    end
    trig_i = 1'b0; s_valid_i = 1'b0;
    for (int t = 0; t < 20 && busy_o; t++) step();
    checks++;
    if (trig_miss_o !== 1'b1) begin errors++; $display("FAIL miss_flag got %b want 1", trig_miss_o); end
    checks++;
    if (q_data.size() != 8 || frame_cnt_o !== 32'd3) begin
      errors++; $display("FAIL miss_frame got %0d beats cnt %0d want 8 cnt 3", q_data.size(), frame_cnt_o);
    end else begin
      checks++;
      if (q_data[7] !== 32'hA000_0008 || q_last[7] !== 1'b1 || q_data[2] !== 32'hA000_0003) begin
        errors++; $display("FAIL miss_data got %h/%b want a0000008/1", q_data[7], q_last[7]);
      end
    end
    clr_flags_i = 1'b1;
    step();
    clr_flags_i = 1'b0;
    checks++;
    if (trig_miss_o !== 1'b0 || overflow_o !== 1'b0) begin
      errors++; $display("FAIL miss_clr got %b/%b want 0/0", trig_miss_o, overflow_o);
    end
  endtask

  task automatic test_disabled_zero();
    q_data.delete(); q_last.delete();
    en_i = 1'b0; frame_len_i = 16'd8; trig_i = 1'b1; s_valid_i = 1'b1; s_data_i = 32'h11;
    step();
    trig_i = 1'b0;
    step(); step();
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL dis_busy got %b want 0", busy_o); end
    en_i = 1'b1; frame_len_i = 16'd0; trig_i = 1'b1;
    step();
    trig_i = 1'b0;
    for (int i = 0; i < 5; i++) step();
    s_valid_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || m_axis_tvalid !== 1'b0 || q_data.size() != 0) begin
      errors++; $display("FAIL zero_len got b%b v%b n%0d want b0 v0 n0", busy_o, m_axis_tvalid, q_data.size());
    end
    checks++;
    if (overflow_o !== 1'b0 || trig_miss_o !== 1'b0 || frame_cnt_o !== 32'd3) begin
      errors++; $display("FAIL zero_flags got %b%b cnt %0d want 00 cnt 3", overflow_o, trig_miss_o, frame_cnt_o);
    end
  endtask

  task automatic test_reset_mid();
    q_data.delete(); q_last.delete();
    m_axis_tready = 1'b0; frame_len_i = 16'd8; trig_i = 1'b1;
    step();
    trig_i = 1'b0; s_valid_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      s_data_i = 32'hC0 + 32'(i);
      step();
    end
    checks++;
    if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL mid_buf got %b want 1", m_axis_tvalid); end
    rst = 1'b1; s_data_i = 32'hC5;
    step();
    rst = 1'b0; s_valid_i = 1'b0;
    checks++;
    if (m_axis_tvalid !== 1'b0 || busy_o !== 1'b0 || frame_cnt_o !== 32'd0) begin
      errors++; $display("FAIL mid_rst got v%b b%b cnt %0d want v0 b0 cnt 0", m_axis_tvalid, busy_o, frame_cnt_o);
    end
    step();
    m_axis_tready = 1'b1; trig_i = 1'b1;
    step();
    trig_i = 1'b0; s_valid_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      s_data_i = 32'hE0 + 32'(i);
      step();
    end
    s_valid_i = 1'b0;
    for (int t = 0; t < 20 && busy_o; t++) step();
    checks++;
    if (q_data.size() != 8 || frame_cnt_o !== 32'd1) begin
      errors++; $display("FAIL mid_new got %0d beats cnt %0d want 8 cnt 1", q_data.size(), frame_cnt_o);
    end else begin
      checks++;
      if (q_data[0] !== 32'hE1 || q_data[7] !== 32'hE8 || q_last[7] !== 1'b1 || q_last[6] !== 1'b0) begin
        errors++; $display("FAIL mid_data got %h..%h/%b want e1..e8/1", q_data[0], q_data[7], q_last[7]);
      end
    end
  endtask

  task automatic test_sparse();
    logic        stalled;
    logic [31:0] held;
    int          n;
    q_data.delete(); q_last.delete();
    stalled = 1'b0; held = '0; n = 0;
    frame_len_i = 16'd4; m_axis_tready = 1'b1; trig_i = 1'b1;
    step();
    trig_i = 1'b0;
    for (int c = 0; c < 60; c++) begin
      s_valid_i = (c % 10 == 9);
      if (c % 10 == 9) begin n++; s_data_i = {16'(n), 16'(16'hFFFF - 16'(n))}; end
      m_axis_tready = c[0];
      if (stalled) begin
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== held) begin
          errors++; $display("FAIL sparse_stall c%0d got %b/%h want 1/%h", c, m_axis_tvalid, m_axis_tdata, held);
        end
      end
      stalled = m_axis_tvalid && !m_axis_tready;
      held = m_axis_tdata;
      step();
    end
    s_valid_i = 1'b0; m_axis_tready = 1'b1;
    for (int t = 0; t < 20 && busy_o; t++) step();
    checks++;
    if (q_data.size() != 4 || frame_cnt_o !== 32'd2) begin
      errors++; $display("FAIL sparse_beats got %0d cnt %0d want 4 cnt 2", q_data.size(), frame_cnt_o);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (q_data[i] !== {16'(i+1), 16'(16'hFFFF - 16'(i+1))} || q_last[i] !== (i == 3)) begin
          errors++; $display("FAIL sparse_beat%0d got %h/%b want %h/%b", i, q_data[i], q_last[i],
                             {16'(i+1), 16'(16'hFFFF - 16'(i+1))}, (i == 3));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_trig_miss();
    test_disabled_zero();
    test_reset_mid();
    test_sparse();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
